clint: RTL and testbench

Core-local interruptor for the single-hart NPC core. It holds the memory-mapped machine timer (`mtime`, `mtimecmp`) and the software-interrupt bit (`msip`), and it serves load/store requests from the LSU over a valid/ready request/response port. It drives the level timer-interrupt line into the CSR block's clint input. The CSR block applies the `mstatus.MIE` / `mie.MTIE` gating and performs trap entry.

---
 rtl/clint_pkg.sv | 45 ++++
 rtl/clint_timer.sv | 49 ++++
 rtl/clint.sv | 118 +++++++++++
 tb/tb_clint.sv | 187 ++++++++++++++++++
 4 files changed

// File: rtl/clint_pkg.sv
// Shared definitions for the core-local interruptor: register offsets, reset values,
// FSM encodings, the LSU request payload and the byte-merge helper.
package clint_pkg;

  localparam int unsigned XLEN  = 64;
  localparam int unsigned MASKW = XLEN / 8;

  localparam logic [15:0] CLINT_MSIP_OFF     = 16'h0000;
  localparam logic [15:0] CLINT_MTIMECMP_OFF = 16'h4000;
  localparam logic [15:0] CLINT_MTIME_OFF    = 16'hBFF8;

  localparam logic [XLEN-1:0] CLINT_MTIMECMP_RST = {XLEN{1'b1}};

  typedef enum logic {
    CLINT_ST_IDLE = 1'b0,
    CLINT_ST_RESP = 1'b1
  } clint_state_e;

  typedef enum logic [1:0] {
    CLINT_SEL_NONE     = 2'd0,
    CLINT_SEL_MSIP     = 2'd1,
    CLINT_SEL_MTIMECMP = 2'd2,
    CLINT_SEL_MTIME    = 2'd3
  } clint_sel_e;

  typedef struct packed {
    logic             wen;
    logic [XLEN-1:0]  addr;
    logic [XLEN-1:0]  wdata;
    logic [MASKW-1:0] wmask;
  } clint_req_t;

  // Replace only the byte lanes enabled in mask.
  function automatic logic [XLEN-1:0] merge_bytes(input logic [XLEN-1:0]  old_val,
                                                  input logic [XLEN-1:0]  new_val,
                                                  input logic [MASKW-1:0] mask);
    logic [XLEN-1:0] res;
    res = old_val;
    for (int i = 0; i < int'(MASKW); i++) begin
      if (mask[i]) res[i*8 +: 8] = new_val[i*8 +: 8];
    end
    return res;
  endfunction

endpackage

// File: rtl/clint_timer.sv
// Machine timer: prescaler, mtime, mtimecmp with byte-merged stores, and the
// registered mtime >= mtimecmp compare driving the timer interrupt.
module clint_timer
  import clint_pkg::*;
#(
  parameter int unsigned TICK_DIV = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             cmp_we,
  input  logic             time_we,
  input  logic [XLEN-1:0]  wdata,
  input  logic [MASKW-1:0] wmask,
  output logic [XLEN-1:0]  mtime,
  output logic [XLEN-1:0]  mtimecmp,
  output logic             irq
);

  localparam int unsigned PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [PW-1:0] PRESC_MAX = PW'(TICK_DIV - 1);

  logic [PW-1:0] presc;
  logic          tick_c;

  assign tick_c = (presc == PRESC_MAX);

  // A store to mtime beats a coincident tick and restarts the prescaler.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      presc    <= '0;
      mtime    <= '0;
      mtimecmp <= CLINT_MTIMECMP_RST;
      irq      <= 1'b0;
    end else begin
      if (time_we) begin
        mtime <= merge_bytes(mtime, wdata, wmask);
        presc <= '0;
      end else if (tick_c) begin
        mtime <= mtime + 64'd1;
        presc <= '0;
      end else begin
        presc <= presc + PW'(1);
      end
      if (cmp_we) mtimecmp <= merge_bytes(mtimecmp, wdata, wmask);
      irq <= (mtime >= mtimecmp);
    end
  end

endmodule

// File: rtl/clint.sv
// Core-local interruptor top: address decode, request/response FSM, msip and
// the machine timer instance.
module clint
  import clint_pkg::*;
#(
  parameter logic [63:0] BASE_ADDR = 64'h0000_0000_0200_0000,
  parameter int unsigned TICK_DIV  = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        i_req_valid,
  output logic        o_req_ready,
  input  logic        i_req_wen,
  input  logic [63:0] i_req_addr,
  input  logic [63:0] i_req_wdata,
  input  logic [7:0]  i_req_wmask,
  output logic        o_rsp_valid,
  input  logic        i_rsp_ready,
  output logic [63:0] o_rsp_rdata,
  output logic        o_rsp_err,
  output logic        o_timer_irq,
  output logic        o_soft_irq
);

  clint_req_t      req;
  clint_state_e    state;
  clint_sel_e      sel_c;
  logic [XLEN-1:0] rdata_c;
  logic [XLEN-1:0] mtime;
  logic [XLEN-1:0] mtimecmp;
  logic            msip;
  logic            accept_c;
  logic            msip_we_c;
  logic            addr_unused;

  assign req = '{wen: i_req_wen, addr: i_req_addr, wdata: i_req_wdata, wmask: i_req_wmask};
  assign addr_unused = ^req.addr[2:0];

  // Word decode inside the 64 KiB window; anything else is an access fault.
  always_comb begin
    sel_c = CLINT_SEL_NONE;
    if (req.addr[63:16] == BASE_ADDR[63:16]) begin
      case (req.addr[15:3])
        CLINT_MSIP_OFF[15:3]:     sel_c = CLINT_SEL_MSIP;
        CLINT_MTIMECMP_OFF[15:3]: sel_c = CLINT_SEL_MTIMECMP;
        CLINT_MTIME_OFF[15:3]:    sel_c = CLINT_SEL_MTIME;
        default:                  sel_c = CLINT_SEL_NONE;
      endcase
    end
  end

  always_comb begin
    rdata_c = '0;
    case (sel_c)
      CLINT_SEL_MSIP:     rdata_c = {63'd0, msip};
      CLINT_SEL_MTIMECMP: rdata_c = mtimecmp;
      CLINT_SEL_MTIME:    rdata_c = mtime;
      default:            rdata_c = '0;
    endcase
  end

  assign accept_c  = i_req_valid && (state == CLINT_ST_IDLE);
  assign msip_we_c = accept_c && req.wen && (sel_c == CLINT_SEL_MSIP) && req.wmask[0];

  clint_timer #(
    .TICK_DIV (TICK_DIV)
  ) u_timer (
    .clk      (clk),
    .rst_n    (rst_n),
    .cmp_we   (accept_c && req.wen && (sel_c == CLINT_SEL_MTIMECMP)),
    .time_we  (accept_c && req.wen && (sel_c == CLINT_SEL_MTIME)),
    .wdata    (req.wdata),
    .wmask    (req.wmask),
    .mtime    (mtime),
    .mtimecmp (mtimecmp),
    .irq      (o_timer_irq)
  );

  // Response is captured at the accept edge and held until the LSU takes it.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= CLINT_ST_IDLE;
      o_req_ready <= 1'b1;
      o_rsp_valid <= 1'b0;
      o_rsp_rdata <= '0;
      o_rsp_err   <= 1'b0;
      msip        <= 1'b0;
    end else begin
      case (state)
        CLINT_ST_IDLE: begin
          if (accept_c) begin
            state       <= CLINT_ST_RESP;
            o_req_ready <= 1'b0;
            o_rsp_valid <= 1'b1;
            o_rsp_rdata <= req.wen ? '0 : rdata_c;
            o_rsp_err   <= (sel_c == CLINT_SEL_NONE);
            if (msip_we_c) msip <= req.wdata[0];
          end
        end
        CLINT_ST_RESP: begin
          if (i_rsp_ready) begin
            state       <= CLINT_ST_IDLE;
            o_req_ready <= 1'b1;
            o_rsp_valid <= 1'b0;
          end
        end
        default: begin
          state       <= CLINT_ST_IDLE;
          o_req_ready <= 1'b1;
          o_rsp_valid <= 1'b0;
        end
      endcase
    end
  end

  assign o_soft_irq = msip;

endmodule

// File: tb/tb_clint.sv
// Directed bench for clint: one instance with TICK_DIV=1 and one with TICK_DIV=4.
module tb_clint;

  localparam logic [63:0] BASE   = 64'h0000_0000_0200_0000;
  localparam logic [63:0] A_MSIP = BASE;
  localparam logic [63:0] A_CMP  = BASE + 64'h4000;
  localparam logic [63:0] A_TIME = BASE + 64'hBFF8;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [1:0]  req_valid, req_ready, req_wen, rsp_valid, rsp_ready, rsp_err;
  logic [1:0]  timer_irq, soft_irq;
  logic [63:0] req_addr  [2];
  logic [63:0] req_wdata [2];
  logic [7:0]  req_wmask [2];
  logic [63:0] rsp_rdata [2];

  int unsigned cyc, passes, total;
  logic [63:0] rd;
  logic        er;

  always #5 clk = ~clk;

  clint #(.BASE_ADDR(BASE), .TICK_DIV(1)) dut (
    .clk(clk), .rst_n(rst_n),
    .i_req_valid(req_valid[0]), .o_req_ready(req_ready[0]), .i_req_wen(req_wen[0]),
    .i_req_addr(req_addr[0]), .i_req_wdata(req_wdata[0]), .i_req_wmask(req_wmask[0]),
    .o_rsp_valid(rsp_valid[0]), .i_rsp_ready(rsp_ready[0]), .o_rsp_rdata(rsp_rdata[0]),
    .o_rsp_err(rsp_err[0]), .o_timer_irq(timer_irq[0]), .o_soft_irq(soft_irq[0])
  );

  clint #(.BASE_ADDR(BASE), .TICK_DIV(4)) dut4 (
    .clk(clk), .rst_n(rst_n),
    .i_req_valid(req_valid[1]), .o_req_ready(req_ready[1]), .i_req_wen(req_wen[1]),
    .i_req_addr(req_addr[1]), .i_req_wdata(req_wdata[1]), .i_req_wmask(req_wmask[1]),
    .o_rsp_valid(rsp_valid[1]), .i_rsp_ready(rsp_ready[1]), .o_rsp_rdata(rsp_rdata[1]),
    .o_rsp_err(rsp_err[1]), .o_timer_irq(timer_irq[1]), .o_soft_irq(soft_irq[1])
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) passes++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  task automatic step();
    @(posedge clk);
    cyc++;
    #1;
  endtask

  task automatic wait_until(input int unsigned t);
    if (cyc > t) check("schedule", 64'(cyc), 64'(t));
    while (cyc < t) step();
  endtask

  // One request: accept on the next edge, LSU takes the response on the edge after.
  task automatic xact(input int idx, input logic wen, input logic [63:0] addr,
                      input logic [63:0] wdata, input logic [7:0] wmask,
                      output logic [63:0] rdata, output logic err);
    req_valid[idx] = 1'b1;
    req_wen[idx]   = wen;
    req_addr[idx]  = addr;
    req_wdata[idx] = wdata;
    req_wmask[idx] = wmask;
    step();
    check("rsp_valid_after_accept", 64'(rsp_valid[idx]), 64'd1);
    rdata = rsp_rdata[idx];
    err   = rsp_err[idx];
    req_valid[idx] = 1'b0;
    step();
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: bench did not complete");
    $fatal(1);
  end

  initial begin
    passes = 0; total = 0; cyc = 0;
    rst_n = 1'b0;
    req_valid = '0; req_wen = '0; rsp_ready = 2'b11;
    for (int i = 0; i < 2; i++) begin
      req_addr[i] = '0; req_wdata[i] = '0; req_wmask[i] = '0;
    end
    step(); step();
    check("rst_req_ready", 64'(req_ready[0]), 64'd1);
    check("rst_rsp_valid", 64'(rsp_valid[0]), 64'd0);
    check("rst_rsp_rdata", rsp_rdata[0], 64'd0);
    check("rst_rsp_err", 64'(rsp_err[0]), 64'd0);
    check("rst_timer_irq", 64'(timer_irq[0]), 64'd0);
    check("rst_soft_irq", 64'(soft_irq[0]), 64'd0);
    check("rst_req_ready4", 64'(req_ready[1]), 64'd1);
    rst_n = 1'b1;
    cyc = 0;

    // mtime equals the edge count since reset release; load sees the pre-edge value
    wait_until(4);
    xact(0, 1'b0, A_TIME, 64'd0, 8'h00, rd, er);
    check("load_mtime_c5", rd, 64'd4);
    check("load_mtime_err", 64'(er), 64'd0);
    check("irq_low_early", 64'(timer_irq[0]), 64'd0);

    xact(0, 1'b1, A_CMP, 64'd20, 8'hFF, rd, er);
    check("store_rdata_zero", rd, 64'd0);
    wait_until(20);
    check("irq_before_k", 64'(timer_irq[0]), 64'd0);
    step();
    check("irq_rise_k_plus_1", 64'(timer_irq[0]), 64'd1);
    xact(0, 1'b1, A_CMP, 64'd1000, 8'hFF, rd, er);
    check("irq_drop_cmp_raise", 64'(timer_irq[0]), 64'd0);

    // wrap: mtime = FFFE at edge 26, so mtime after edge c is c-28
    xact(0, 1'b1, A_CMP, 64'd5, 8'hFF, rd, er);
    xact(0, 1'b1, A_TIME, 64'hFFFF_FFFF_FFFF_FFFE, 8'hFF, rd, er);
    check("irq_high_pre_wrap", 64'(timer_irq[0]), 64'd1);
    step();
    check("irq_high_at_ffff", 64'(timer_irq[0]), 64'd1);
    step();
    check("irq_low_after_wrap", 64'(timer_irq[0]), 64'd0);
    wait_until(33);
    check("irq_low_mtime4", 64'(timer_irq[0]), 64'd0);
    step();
    check("irq_rerise_mtime5", 64'(timer_irq[0]), 64'd1);
    xact(0, 1'b0, A_TIME, 64'd0, 8'h00, rd, er);
    check("load_mtime_wrapped", rd, 64'd6);

    xact(0, 1'b1, A_MSIP, 64'hFFFF, 8'h01, rd, er);
    check("soft_irq_set", 64'(soft_irq[0]), 64'd1);
    xact(0, 1'b0, A_MSIP, 64'd0, 8'h00, rd, er);
    check("load_msip", rd, 64'd1);
    check("load_msip_err", 64'(er), 64'd0);
    xact(0, 1'b0, BASE + 64'h8, 64'd0, 8'h00, rd, er);
    check("unmapped_load_err", 64'(er), 64'd1);
    check("unmapped_load_rdata", rd, 64'd0);
    xact(0, 1'b1, BASE + 64'h8, 64'd0, 8'hFF, rd, er);
    check("unmapped_store_err", 64'(er), 64'd1);
    check("unmapped_store_no_effect", 64'(soft_irq[0]), 64'd1);
    xact(0, 1'b0, BASE + 64'h1_4000, 64'd0, 8'h00, rd, er);
    check("outside_window_err", 64'(er), 64'd1);
    check("outside_window_rdata", rd, 64'd0);

    // TICK_DIV=4 ticks on edges 4k; edge 48 is a tick edge
    wait_until(47);
    xact(1, 1'b1, A_TIME, 64'd100, 8'hFF, rd, er);
    check("div4_store_err", 64'(er), 64'd0);
    xact(1, 1'b0, A_TIME, 64'd0, 8'h00, rd, er);
    check("div4_store_wins_tick", rd, 64'd100);
    xact(1, 1'b0, A_TIME, 64'd0, 8'h00, rd, er);
    check("div4_load_on_tick_pre", rd, 64'd100);
    xact(1, 1'b0, A_TIME, 64'd0, 8'h00, rd, er);
    check("div4_first_increment", rd, 64'd101);

    // response backpressure with a request held pending
    req_valid[0] = 1'b1; req_wen[0] = 1'b0; req_addr[0] = A_TIME;
    rsp_ready[0] = 1'b0;
    step();
    check("stall_accept_valid", 64'(rsp_valid[0]), 64'd1);
    check("stall_accept_rdata", rsp_rdata[0], 64'd27);
    for (int i = 0; i < 3; i++) begin
      step();
      check("stall_req_ready", 64'(req_ready[0]), 64'd0);
      check("stall_rsp_valid", 64'(rsp_valid[0]), 64'd1);
      check("stall_rdata_stable", rsp_rdata[0], 64'd27);
      check("stall_err_stable", 64'(rsp_err[0]), 64'd0);
    end
    rsp_ready[0] = 1'b1;
    step();
    check("release_rsp_valid", 64'(rsp_valid[0]), 64'd0);
    check("release_req_ready", 64'(req_ready[0]), 64'd1);
    step();
    check("second_accept_valid", 64'(rsp_valid[0]), 64'd1);
    check("second_accept_rdata", rsp_rdata[0], 64'd32);
    req_valid[0] = 1'b0;
    step();

    // partial MTIME store merges with the pre-increment value 0x22
    xact(0, 1'b1, A_TIME, 64'hAA00, 8'h02, rd, er);
    xact(0, 1'b0, A_TIME, 64'd0, 8'h00, rd, er);
    check("partial_mtime_merge", rd, 64'hAA23);

    $display("%0d/%0d checks passed", passes, total);
    $finish;
  end

endmodule
